btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_pkg.sv | 15 +
 rtl/btn_if.sv | 19 +
 rtl/btn_sync_debounce.sv | 53 +++++
 rtl/btn_conditioner.sv | 120 ++++++++++++
 tb/tb_btn_conditioner.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// Shared types and default timing for the pushbutton conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } gesture_state_e;

    localparam int unsigned CLK_HZ           = 50_000_000;
    localparam int unsigned DEBOUNCE_DEFAULT = 50_000;
    localparam int unsigned LONG_DEFAULT     = 100_000;
    localparam int unsigned REPEAT_DEFAULT   = 50_000;

endpackage

// File: rtl/btn_if.sv
// Conditioned button events plus the gesture state, grouped for the consumer.
interface btn_if;

    logic                   btn_level;
    logic                   press_pulse;
    logic                   release_pulse;
    logic                   long_pulse;
    logic                   repeat_pulse;
    btn_pkg::gesture_state_e state;

    modport master (
        output btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, state
    );

    modport slave (
        input btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, state
    );

endinterface

// File: rtl/btn_sync_debounce.sv
// Two-flop synchronizer, active-high conversion and consecutive-cycle debounce.
module btn_sync_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = btn_pkg::DEBOUNCE_DEFAULT,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic btn_reset,
    input  logic btn_raw,
    output logic btn_level
);

    localparam logic [CNT_W-1:0] DB_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             pressed_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Synchronizer flops reset to the released (high) raw level.
    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            pressed_q <= 1'b0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            pressed_q <= ~sync2_q;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
        end
    end

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (pressed_q != level_q) begin
            if (cnt_q == DB_TERM) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign btn_level = level_q;

endmodule

// File: rtl/btn_conditioner.sv
// Debounced pushbutton with press/release strobes and long-press auto-repeat.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned LONG_CYCLES     = LONG_DEFAULT,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_DEFAULT
) (
    input  logic  clk,
    input  logic  btn_reset,
    input  logic  btn_raw,
    btn_if.master evt
);

    localparam int unsigned MAX_DL = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
    localparam int unsigned MAX_C  = (MAX_DL > REPEAT_CYCLES) ? MAX_DL : REPEAT_CYCLES;
    localparam int unsigned CNT_W  = $clog2(MAX_C + 1);

    localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'(REPEAT_CYCLES - 1);

    logic             level;
    logic             level_prev_q;
    logic             rise;
    logic             fall;
    gesture_state_e   state_q;
    gesture_state_e   state_d;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] hold_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             rep_q, rep_d;

    btn_sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_sync_debounce (
        .clk       (clk),
        .btn_reset (btn_reset),
        .btn_raw   (btn_raw),
        .btn_level (level)
    );

    assign rise = level & ~level_prev_q;
    assign fall = ~level & level_prev_q;

    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) begin
            level_prev_q <= 1'b0;
            state_q      <= IDLE;
            hold_q       <= '0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_q       <= 1'b0;
            rep_q        <= 1'b0;
        end else begin
            level_prev_q <= level;
            state_q      <= state_d;
            hold_q       <= hold_d;
            press_q      <= press_d;
            release_q    <= release_d;
            long_q       <= long_d;
            rep_q        <= rep_d;
        end
    end

    // A fall checked before the terminal counts lets release win over long/repeat.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        press_d   = rise;
        release_d = fall;
        long_d    = 1'b0;
        rep_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HELD;
                    hold_d  = '0;
                end
            end
            HELD: begin
                if (fall) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else if (hold_q == LONG_TERM) begin
                    long_d  = 1'b1;
                    state_d = REPEAT;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            REPEAT: begin
                if (fall) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else if (hold_q == REP_TERM) begin
                    rep_d  = 1'b1;
                    hold_d = '0;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    assign evt.btn_level     = level;
    assign evt.press_pulse   = press_q;
    assign evt.release_pulse = release_q;
    assign evt.long_pulse    = long_q;
    assign evt.repeat_pulse  = rep_q;
    assign evt.state         = state_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE=8, LONG=32, REPEAT=16.
module tb_btn_conditioner;
    import btn_pkg::*;

    localparam int D = 8;
    localparam int L = 32;
    localparam int R = 16;

    logic clk       = 1'b0;
    logic btn_reset = 1'b1;
    logic btn_raw   = 1'b1;

    btn_if evt_if ();

    btn_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .REPEAT_CYCLES   (R)
    ) dut (
        .clk       (clk),
        .btn_reset (btn_reset),
        .btn_raw   (btn_raw),
        .evt       (evt_if)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    int press_n = 0, release_n = 0, long_n = 0, repeat_n = 0, rise_n = 0, fall_n = 0;
    int onehot_err = 0;
    int last_press = -1, last_release = -1, last_long = -1, last_rise = -1, last_fall = -1;
    int rep_cycles[$];
    logic lvl_prev = 1'b0;

    // Event log: cyc equals the index of the most recent rising edge.
    always @(negedge clk) begin
        if (evt_if.press_pulse)   begin press_n++;   last_press = cyc;   end
        if (evt_if.release_pulse) begin release_n++; last_release = cyc; end
        if (evt_if.long_pulse)    begin long_n++;    last_long = cyc;    end
        if (evt_if.repeat_pulse)  begin repeat_n++;  rep_cycles.push_back(cyc); end
        if (evt_if.btn_level === 1'b1 && lvl_prev === 1'b0) begin rise_n++; last_rise = cyc; end
        if (evt_if.btn_level === 1'b0 && lvl_prev === 1'b1) begin fall_n++; last_fall = cyc; end
        lvl_prev = evt_if.btn_level;
        if ($countones({evt_if.press_pulse, evt_if.release_pulse,
                        evt_if.long_pulse, evt_if.repeat_pulse}) > 1) onehot_err++;
    end

    task automatic wait_until(input int target);
        int guard = 0;
        while (cyc < target && guard < 5000) begin
            @(negedge clk); #1;
            guard++;
        end
        if (cyc < target) begin
            checks++; failures++;
            $display("FAIL wait_until: cyc %0d required %0d", cyc, target);
        end
    endtask

    task automatic do_press(output int p);
        int n;
        @(negedge clk); #1;
        btn_raw = 1'b0;
        n = cyc + 1;
        p = n + 11;
        wait_until(n + 12);
    endtask

    task automatic test_reset();
        logic [4:0] outs;
        btn_raw   = 1'b1;
        btn_reset = 1'b0;
        repeat (10) begin
            @(negedge clk); #1;
            outs = {evt_if.btn_level, evt_if.press_pulse, evt_if.release_pulse,
                    evt_if.long_pulse, evt_if.repeat_pulse};
            checks++;
            if (outs !== 5'b0) begin failures++; $display("FAIL reset_outs: got %b required 00000", outs); end
        end
        checks++;
        if (evt_if.state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d required %0d", evt_if.state, IDLE); end
        btn_reset = 1'b1;
        repeat (20) begin
            @(negedge clk); #1;
            outs = {evt_if.btn_level, evt_if.press_pulse, evt_if.release_pulse,
                    evt_if.long_pulse, evt_if.repeat_pulse};
            checks++;
            if (outs !== 5'b0) begin failures++; $display("FAIL post_reset_outs: got %b required 00000", outs); end
        end
    endtask

    task automatic test_press();
        int n;
        int p0;
        p0 = press_n;
        @(negedge clk); #1;
        btn_raw = 1'b0;
        n = cyc + 1;
        wait_until(n + 12);
        checks++;
        if (last_rise !== n + 10) begin failures++; $display("FAIL press_level_edge: got %0d required %0d", last_rise, n + 10); end
        checks++;
        if (last_press !== n + 11) begin failures++; $display("FAIL press_pulse_edge: got %0d required %0d", last_press, n + 11); end
        checks++;
        if (press_n - p0 !== 1) begin failures++; $display("FAIL press_count: got %0d required 1", press_n - p0); end
        checks++;
        if (evt_if.btn_level !== 1'b1) begin failures++; $display("FAIL press_level: got %b required 1", evt_if.btn_level); end
        checks++;
        if (evt_if.state !== HELD) begin failures++; $display("FAIL press_state: got %0d required %0d", evt_if.state, HELD); end
    endtask

    task automatic test_long_repeat();
        int p;
        int r;
        int rl0;
        logic [31:0] exp_q[$];
        p = last_press;
        rl0 = release_n;
        wait_until(p + 98);
        checks++;
        if (last_long !== p + L) begin failures++; $display("FAIL long_edge: got %0d required %0d", last_long, p + L); end
        checks++;
        if (long_n !== 1) begin failures++; $display("FAIL long_count: got %0d required 1", long_n); end
        exp_q = '{p + 48, p + 64, p + 80, p + 96};
        checks++;
        if (rep_cycles.size() !== exp_q.size()) begin
            failures++; $display("FAIL repeat_count: got %0d required %0d", rep_cycles.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (rep_cycles[i] !== int'(exp_q[i])) begin
                    failures++; $display("FAIL repeat_edge_%0d: got %0d required %0d", i, rep_cycles[i], exp_q[i]);
                end
            end
        end
        btn_raw = 1'b1;
        r = cyc + 1;
        wait_until(r + 14);
        checks++;
        if (last_fall !== r + 10) begin failures++; $display("FAIL release_level_edge: got %0d required %0d", last_fall, r + 10); end
        checks++;
        if (last_release !== r + 11) begin failures++; $display("FAIL release_pulse_edge: got %0d required %0d", last_release, r + 11); end
        checks++;
        if (release_n - rl0 !== 1) begin failures++; $display("FAIL release_count: got %0d required 1", release_n - rl0); end
        checks++;
        if (rep_cycles.size() !== 4) begin failures++; $display("FAIL repeat_after_release: got %0d required 4", rep_cycles.size()); end
        checks++;
        if (evt_if.state !== IDLE) begin failures++; $display("FAIL release_state: got %0d required %0d", evt_if.state, IDLE); end
    endtask

    task automatic test_glitch();
        int c0;
        int rise0;
        c0 = press_n + release_n + long_n + repeat_n;
        rise0 = rise_n;
        @(negedge clk); #1;
        btn_raw = 1'b0;
        repeat (5) begin @(negedge clk); #1; end
        btn_raw = 1'b1;
        repeat (3) begin @(negedge clk); #1; end
        btn_raw = 1'b0;
        repeat (5) begin @(negedge clk); #1; end
        btn_raw = 1'b1;
        repeat (30) begin @(negedge clk); #1; end
        checks++;
        if (rise_n !== rise0) begin failures++; $display("FAIL glitch_level: got %0d rises required %0d", rise_n, rise0); end
        checks++;
        if (press_n + release_n + long_n + repeat_n !== c0) begin
            failures++; $display("FAIL glitch_pulses: got %0d required %0d", press_n + release_n + long_n + repeat_n, c0);
        end
    endtask

    task automatic test_release_on_repeat();
        int p;
        int rl0;
        int lg0;
        rep_cycles.delete();
        rl0 = release_n;
        lg0 = long_n;
        do_press(p);
        checks++;
        if (last_press !== p) begin failures++; $display("FAIL tc_press_edge: got %0d required %0d", last_press, p); end
        wait_until(p + 52);
        btn_raw = 1'b1;
        wait_until(p + 70);
        checks++;
        if (last_fall !== p + 63) begin failures++; $display("FAIL tc_level_edge: got %0d required %0d", last_fall, p + 63); end
        checks++;
        if (last_release !== p + 64) begin failures++; $display("FAIL tc_release_edge: got %0d required %0d", last_release, p + 64); end
        checks++;
        if (release_n - rl0 !== 1) begin failures++; $display("FAIL tc_release_count: got %0d required 1", release_n - rl0); end
        checks++;
        if (long_n - lg0 !== 1) begin failures++; $display("FAIL tc_long_count: got %0d required 1", long_n - lg0); end
        checks++;
        if (rep_cycles.size() !== 1) begin
            failures++; $display("FAIL tc_repeat_count: got %0d required 1", rep_cycles.size());
        end else begin
            checks++;
            if (rep_cycles[0] !== p + 48) begin failures++; $display("FAIL tc_repeat_edge: got %0d required %0d", rep_cycles[0], p + 48); end
        end
    endtask

    task automatic test_reset_mid_repeat();
        int p;
        int x;
        int rl0;
        int pr0;
        logic [4:0] outs;
        do_press(p);
        wait_until(p + 40);
        checks++;
        if (evt_if.state !== REPEAT) begin failures++; $display("FAIL mid_state: got %0d required %0d", evt_if.state, REPEAT); end
        rl0 = release_n;
        btn_reset = 1'b0;
        repeat (5) begin
            @(negedge clk); #1;
            outs = {evt_if.btn_level, evt_if.press_pulse, evt_if.release_pulse,
                    evt_if.long_pulse, evt_if.repeat_pulse};
            checks++;
            if (outs !== 5'b0) begin failures++; $display("FAIL mid_reset_outs: got %b required 00000", outs); end
        end
        pr0 = press_n;
        btn_reset = 1'b1;
        x = cyc;
        wait_until(x + 14);
        checks++;
        if (release_n !== rl0) begin failures++; $display("FAIL mid_no_release: got %0d required %0d", release_n, rl0); end
        checks++;
        if (press_n - pr0 !== 1) begin failures++; $display("FAIL mid_press_count: got %0d required 1", press_n - pr0); end
        checks++;
        if (last_press !== x + 12) begin failures++; $display("FAIL mid_press_edge: got %0d required %0d", last_press, x + 12); end
        btn_raw = 1'b1;
        wait_until(x + 40);
    endtask

    initial begin
        test_reset();
        test_press();
        test_long_repeat();
        test_glitch();
        test_release_on_repeat();
        test_reset_mid_repeat();
        checks++;
        if (onehot_err !== 0) begin failures++; $display("FAIL pulse_onehot: got %0d overlaps required 0", onehot_err); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
